// File: rtl/div_post_stage_pkg.sv
// Tag layout shared by the divider's operand stage and output stage.
package div_post_stage_pkg;

   localparam int TAG_VALID   = 0;
   localparam int TAG_SIGNED  = 1;
   localparam int TAG_NEG_DVD = 2;
   localparam int TAG_NEG_DVS = 3;
   localparam int TAG_DBZ     = 4;
   localparam int TAG_W       = 5;

endpackage

// File: rtl/div_tag_pipe.sv
// Fixed-depth tag delay line that runs in lockstep with the divider slice chain.
module div_tag_pipe
   import div_post_stage_pkg::*;
#(
   parameter int LAT = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [TAG_W-1:0] issue_tag,
   output logic [TAG_W-1:0] exit_tag
);

   logic [TAG_W-1:0] line [LAT];

   // A flush kills only the valid bits; the payload bits of an invalid entry are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            line[i] <= '0;
         end
      end else begin
         line[0] <= issue_tag;
         for (int i = 1; i < LAT; i++) begin
            line[i] <= line[i-1];
         end
         if (flush) begin
            for (int i = 0; i < LAT; i++) begin
               line[i][TAG_VALID] <= 1'b0;
            end
         end
      end
   end

   assign exit_tag = line[LAT-1];

endmodule

// File: rtl/div_post_stage.sv
// Output stage of the pipelined restoring divider: re-joins each op's tag with the
// unsigned slice-chain result and registers the sign-corrected quotient/remainder.
module div_post_stage
   import div_post_stage_pkg::*;
#(
   parameter int N   = 8,
   parameter int LAT = N
)
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       tag_valid_i,
   input  logic                       tag_signed_i,
   input  logic                       tag_neg_dvd_i,
   input  logic                       tag_neg_dvs_i,
   input  logic                       tag_dbz_i,
   input  logic [N-1:0]               quotient_i,
   input  logic [N-1:0]               remainder_i,
   output logic                       valid_o,
   output logic [N-1:0]               quotient_o,
   output logic [N-1:0]               remainder_o,
   output logic                       dbz_o,
   output logic [$clog2(LAT+1)-1:0]   inflight_o
);

   localparam int CW = $clog2(LAT+1);

   logic [TAG_W-1:0] issue_tag;
   logic [TAG_W-1:0] exit_tag;
   logic             exit_valid;
   logic             q_neg;
   logic             r_neg;
   logic [N-1:0]     q_fix;
   logic [N-1:0]     r_fix;

   always_comb begin
      issue_tag              = '0;
      issue_tag[TAG_VALID]   = tag_valid_i;
      issue_tag[TAG_SIGNED]  = tag_signed_i;
      issue_tag[TAG_NEG_DVD] = tag_neg_dvd_i;
      issue_tag[TAG_NEG_DVS] = tag_neg_dvs_i;
      issue_tag[TAG_DBZ]     = tag_dbz_i;
   end

   div_tag_pipe #(.LAT(LAT)) u_tag_pipe (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_i),
      .issue_tag (issue_tag),
      .exit_tag  (exit_tag)
   );

   assign exit_valid = exit_tag[TAG_VALID];

   // Divide-by-zero forces an all-ones quotient, but the remainder still takes the
   // dividend's sign so the original dividend comes back out.
   always_comb begin
      q_neg = exit_tag[TAG_SIGNED] & (exit_tag[TAG_NEG_DVD] ^ exit_tag[TAG_NEG_DVS]);
      r_neg = exit_tag[TAG_SIGNED] & exit_tag[TAG_NEG_DVD];
      q_fix = q_neg ? -quotient_i : quotient_i;
      if (exit_tag[TAG_DBZ]) begin
         q_fix = '1;
      end
      r_fix = r_neg ? -remainder_i : remainder_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_o     <= 1'b0;
         quotient_o  <= '0;
         remainder_o <= '0;
         dbz_o       <= 1'b0;
         inflight_o  <= '0;
      end else begin
         valid_o     <= exit_valid & ~flush_i;
         dbz_o       <= exit_valid & exit_tag[TAG_DBZ] & ~flush_i;
         quotient_o  <= q_fix;
         remainder_o <= r_fix;
         if (flush_i) begin
            inflight_o <= '0;
         end else begin
            inflight_o <= inflight_o + CW'(tag_valid_i) - CW'(exit_valid);
         end
      end
   end

endmodule

// File: tb/tb_div_post_stage.sv
// Self-checking bench for div_post_stage with a behavioural slice-chain model feeding it.
module tb_div_post_stage;

   localparam int N   = 8;
   localparam int LAT = 8;
   localparam int CW  = $clog2(LAT+1);

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dbz;
      int           due;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_i;
   logic          tag_valid_i;
   logic          tag_signed_i;
   logic          tag_neg_dvd_i;
   logic          tag_neg_dvs_i;
   logic          tag_dbz_i;
   logic [N-1:0]  quotient_i;
   logic [N-1:0]  remainder_i;
   logic          valid_o;
   logic [N-1:0]  quotient_o;
   logic [N-1:0]  remainder_o;
   logic          dbz_o;
   logic [CW-1:0] inflight_o;

   logic [N-1:0]  mag_q;
   logic [N-1:0]  mag_r;
   logic [N-1:0]  chain_q [LAT];
   logic [N-1:0]  chain_r [LAT];

   exp_t sb[$];
   int   issue_cyc[$];
   int   cyc;
   int   checks;
   int   fails;

   div_post_stage #(.N(N), .LAT(LAT)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (flush_i),
      .tag_valid_i   (tag_valid_i),
      .tag_signed_i  (tag_signed_i),
      .tag_neg_dvd_i (tag_neg_dvd_i),
      .tag_neg_dvs_i (tag_neg_dvs_i),
      .tag_dbz_i     (tag_dbz_i),
      .quotient_i    (quotient_i),
      .remainder_i   (remainder_i),
      .valid_o       (valid_o),
      .quotient_o    (quotient_o),
      .remainder_o   (remainder_o),
      .dbz_o         (dbz_o),
      .inflight_o    (inflight_o)
   );

   always #5 clk = ~clk;

   // Stand-in for the slice chain: magnitudes presented at issue emerge LAT edges later.
   always @(posedge clk) begin
      chain_q[0] <= mag_q;
      chain_r[0] <= mag_r;
      for (int i = 1; i < LAT; i++) begin
         chain_q[i] <= chain_q[i-1];
         chain_r[i] <= chain_r[i-1];
      end
   end

   assign quotient_i  = chain_q[LAT-1];
   assign remainder_i = chain_r[LAT-1];

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive_idle();
      tag_valid_i   = 1'b0;
      tag_signed_i  = 1'($urandom);
      tag_neg_dvd_i = 1'($urandom);
      tag_neg_dvs_i = 1'($urandom);
      tag_dbz_i     = 1'($urandom);
      mag_q         = N'($urandom);
      mag_r         = N'($urandom);
   endtask

   task automatic drive_op(input bit sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                           input bit keep);
      logic [N-1:0] ma;
      logic [N-1:0] mb;
      int           sa;
      int           sbv;
      exp_t         e;
      ma = (sgn && a[N-1]) ? N'(-a) : a;
      mb = (sgn && b[N-1]) ? N'(-b) : b;
      tag_valid_i   = 1'b1;
      tag_signed_i  = sgn;
      tag_neg_dvd_i = a[N-1];
      tag_neg_dvs_i = b[N-1];
      tag_dbz_i     = (b == '0);
      if (mb == '0) begin
         mag_q = '1;
         mag_r = ma;
      end else begin
         mag_q = ma / mb;
         mag_r = ma % mb;
      end
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      if (b == '0) begin
         e.q = '1;
         e.r = a;
      end else if (sgn) begin
         e.q = N'(sa / sbv);
         e.r = N'(sa % sbv);
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      e.dbz = (b == '0);
      e.due = cyc + LAT + 1;
      if (keep) sb.push_back(e);
      issue_cyc.push_back(cyc);
   endtask

   function automatic int exp_inflight();
      int n = 0;
      foreach (issue_cyc[i]) begin
         if (issue_cyc[i] >= cyc - LAT && issue_cyc[i] <= cyc - 1) n++;
      end
      return n;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      flush_i = 1'b0;
      drive_idle();
      step();
      step();
      checks++;
      if (valid_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_valid got %b want 0", valid_o);
      end
      checks++;
      if (quotient_o !== '0) begin
         fails++;
         $display("[TB] FAIL reset_quotient got %h want 00", quotient_o);
      end
      checks++;
      if (remainder_o !== '0) begin
         fails++;
         $display("[TB] FAIL reset_remainder got %h want 00", remainder_o);
      end
      checks++;
      if (dbz_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_dbz got %b want 0", dbz_o);
      end
      checks++;
      if (inflight_o !== '0) begin
         fails++;
         $display("[TB] FAIL reset_inflight got %0d want 0", inflight_o);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_vectors();
      logic [N-1:0] va [6] = '{8'd200, 8'hF9, 8'h05, 8'h05, 8'h80, 8'hFB};
      logic [N-1:0] vb [6] = '{8'd7,   8'h02, 8'h00, 8'h00, 8'hFF, 8'h00};
      bit           vs [6] = '{1'b0,   1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
      exp_t e;
      for (int k = 0; k < 36; k++) begin
         if (k < 18 && k % 3 == 0) drive_op(vs[k/3], va[k/3], vb[k/3], 1'b1);
         else if (k >= 18 && k < 24) drive_op(1'($urandom), N'($urandom), N'($urandom), 1'b1);
         else drive_idle();
         step();
         checks++;
         if (valid_o === 1'b1) begin
            if (sb.size() == 0) begin
               fails++;
               $display("[TB] FAIL vec_unexpected_valid cyc %0d got q=%h r=%h", cyc, quotient_o, remainder_o);
            end else begin
               e = sb.pop_front();
               if (quotient_o !== e.q || remainder_o !== e.r || dbz_o !== e.dbz || cyc != e.due) begin
                  fails++;
                  $display("[TB] FAIL vec_result cyc %0d got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b at cyc %0d",
                           cyc, quotient_o, remainder_o, dbz_o, e.q, e.r, e.dbz, e.due);
               end
            end
         end else if (dbz_o !== 1'b0 || (sb.size() != 0 && sb[0].due <= cyc)) begin
            fails++;
            $display("[TB] FAIL vec_idle cyc %0d got valid=%b dbz=%b want result pending=%0d", cyc, valid_o, dbz_o, sb.size());
            if (sb.size() != 0 && sb[0].due <= cyc) void'(sb.pop_front());
         end
      end
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("[TB] FAIL vec_drain got %0d outstanding want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   run = 0;
      int   ei;
      issue_cyc.delete();
      for (int k = 0; k < 32; k++) begin
         if (k < 12) drive_op(1'($urandom), N'($urandom), N'($urandom_range(255, 1)), 1'b1);
         else drive_idle();
         step();
         ei = exp_inflight();
         checks++;
         if (inflight_o !== CW'(ei)) begin
            fails++;
            $display("[TB] FAIL b2b_inflight cyc %0d got %0d want %0d", cyc, inflight_o, ei);
         end
         checks++;
         if (valid_o === 1'b1) begin
            run++;
            if (sb.size() == 0) begin
               fails++;
               $display("[TB] FAIL b2b_unexpected_valid cyc %0d got q=%h", cyc, quotient_o);
            end else begin
               e = sb.pop_front();
               if (quotient_o !== e.q || remainder_o !== e.r || dbz_o !== e.dbz || cyc != e.due) begin
                  fails++;
                  $display("[TB] FAIL b2b_result cyc %0d got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b at cyc %0d",
                           cyc, quotient_o, remainder_o, dbz_o, e.q, e.r, e.dbz, e.due);
               end
            end
         end else if (dbz_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_idle_dbz cyc %0d got %b want 0", cyc, dbz_o);
         end
      end
      checks++;
      if (run != 12 || sb.size() != 0) begin
         fails++;
         $display("[TB] FAIL b2b_count got %0d results want 12 (outstanding %0d)", run, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_flush(input bit use_rst);
      exp_t e;
      int   ei;
      int   got = 0;
      issue_cyc.delete();
      for (int k = 0; k < 20; k++) begin
         if (k < 4) drive_op(1'($urandom), N'($urandom), N'($urandom_range(255, 1)), 1'b0);
         else if (k == 5) drive_op(1'b1, 8'hF9, 8'h02, 1'b1);
         else drive_idle();
         if (k == 3) begin
            if (use_rst) rst = 1'b1;
            else flush_i = 1'b1;
         end
         step();
         if (k == 3) begin
            rst = 1'b0;
            flush_i = 1'b0;
            issue_cyc.delete();
         end
         ei = exp_inflight();
         checks++;
         if (inflight_o !== CW'(ei)) begin
            fails++;
            $display("[TB] FAIL kill%0d_inflight cyc %0d got %0d want %0d", use_rst, cyc, inflight_o, ei);
         end
         checks++;
         if (valid_o === 1'b1) begin
            got++;
            if (sb.size() == 0) begin
               fails++;
               $display("[TB] FAIL kill%0d_unexpected_valid cyc %0d got q=%h", use_rst, cyc, quotient_o);
            end else begin
               e = sb.pop_front();
               if (quotient_o !== e.q || remainder_o !== e.r || dbz_o !== e.dbz || cyc != e.due) begin
                  fails++;
                  $display("[TB] FAIL kill%0d_result cyc %0d got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b at cyc %0d",
                           use_rst, cyc, quotient_o, remainder_o, dbz_o, e.q, e.r, e.dbz, e.due);
               end
            end
         end else if (dbz_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL kill%0d_idle_dbz cyc %0d got %b want 0", use_rst, cyc, dbz_o);
         end
      end
      checks++;
      if (got != 1 || sb.size() != 0) begin
         fails++;
         $display("[TB] FAIL kill%0d_count got %0d results want 1", use_rst, got);
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog_timeout got no finish want finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      cyc    = 0;
      checks = 0;
      fails  = 0;
      rst    = 1'b1;
      test_reset();
      test_vectors();
      test_back_to_back();
      test_flush(1'b0);
      test_flush(1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
